// File: rtl/seq_pkg.sv
// Shared definitions for the main-control state sequencer.
// Holds the state index enumeration (which also serves as the debug STATE_CODE
// encoding), the one-hot vector type and helpers to encode/validate it.
// Decoder test benches import this package as well.
package seq_pkg;

  localparam int NUM_STATES   = 17;
  localparam int STATE_CODE_W = 5;

  // State indices double as bit positions in the one-hot register and as the
  // binary value reported on STATE_CODE.
  typedef enum logic [STATE_CODE_W-1:0] {
    S_IF0    = 5'd0,
    S_IF1    = 5'd1,
    S_FF0    = 5'd2,
    S_FF1    = 5'd3,
    S_FF2    = 5'd4,
    S_TF0    = 5'd5,
    S_TF1    = 5'd6,
    S_EX0    = 5'd7,
    S_EX1    = 5'd8,
    S_IT0    = 5'd9,
    S_IT1    = 5'd10,
    S_IT2    = 5'd11,
    S_MUL1   = 5'd12,
    S_MUL2_1 = 5'd13,
    S_MUL2_2 = 5'd14,
    S_MUL3   = 5'd15,
    S_MUL4   = 5'd16
  } state_e;

  typedef logic [NUM_STATES-1:0] state_vec_t;

  localparam state_vec_t ONEHOT_IF0 = state_vec_t'(1);

  // OR of the indices of all set bits; exact for any legal one-hot vector.
  function automatic logic [STATE_CODE_W-1:0] encodeState(input state_vec_t oneHot);
    logic [STATE_CODE_W-1:0] code;
    code = '0;
    for (int i = 0; i < NUM_STATES; i++) begin
      if (oneHot[i]) code = code | STATE_CODE_W'(i);
    end
    return code;
  endfunction

  // True when exactly one bit of the vector is set.
  function automatic logic isOneHot(input state_vec_t oneHot);
    return (oneHot != '0) && ((oneHot & (oneHot - state_vec_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/state_sequencer_mul_iter_counter.sv
// Multiply iteration counter for the state sequencer.
// Cleared synchronously on entry to the iteration loop, incremented once per
// MUL2_2 that loops back, and flags the final iteration.
module mul_iter_counter #(
  parameter int MUL_ITER = 16,
  parameter int CNT_W    = 5
) (
  input  logic CLK,
  input  logic CLR,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_terminal
);

  logic [CNT_W-1:0] r_count;

  // Iteration count: async reset, synchronous clear has priority over increment.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_terminal = (r_count == CNT_W'(MUL_ITER - 1));

endmodule

// File: rtl/state_sequencer.sv
// Main-control timing generator. Drives one of 17 one-hot phase strobes per
// cycle, walking fetch, operand fetch, execute/multiply and interrupt entry
// under the control of ISR-derived hints from the decoder.
// Optional build macro SEQ_MWAIT_EN: when defined, MWAIT stalls the sequencer
// in the memory phases IF1, FF1, FF2, TF1, IT1 and IT2; when undefined the
// MWAIT port exists but memory timing is fixed.
module state_sequencer
  import seq_pkg::*;
#(
  parameter int MUL_ITER = 16,
  parameter int CNT_W    = 5
) (
  input  logic                    CLK,
  input  logic                    CLR,
  input  logic                    f_is_D,
  input  logic                    t_is_D,
  input  logic                    is_T_DFive,
  input  logic                    op_MUL,
  input  logic                    op_RIT,
  input  logic                    op_SVC,
  input  logic                    EIT_gate,
  input  logic                    OIT_gate,
  input  logic                    MWAIT,
  output logic                    IF0,
  output logic                    IF1,
  output logic                    FF0,
  output logic                    FF1,
  output logic                    FF2,
  output logic                    TF0,
  output logic                    TF1,
  output logic                    EX0,
  output logic                    EX1,
  output logic                    IT0,
  output logic                    IT1,
  output logic                    IT2,
  output logic                    MUL1,
  output logic                    MUL2_1,
  output logic                    MUL2_2,
  output logic                    MUL3,
  output logic                    MUL4,
  output logic                    MUL_LAST,
  output logic [STATE_CODE_W-1:0] STATE_CODE
);

  state_vec_t r_state;
  state_e     w_curState;
  state_e     w_nextState;
  logic       w_legal;
  logic       w_hold;
  logic       w_enterIt;
  logic       w_mulTerminal;
  logic       w_cntClear;
  logic       w_cntInc;

  // Decode the one-hot register into a state index and a legality flag.
  always_comb begin
    w_legal    = isOneHot(r_state);
    w_curState = state_e'(encodeState(r_state));
  end

`ifdef SEQ_MWAIT_EN
  // Memory-not-ready stalls only the phases that actually wait on memory.
  always_comb begin
    w_hold = 1'b0;
    if (MWAIT && w_legal) begin
      case (w_curState)
        S_IF1, S_FF1, S_FF2, S_TF1, S_IT1, S_IT2: w_hold = 1'b1;
        default:                                  w_hold = 1'b0;
      endcase
    end
  end
`else
  // Fixed-timing memory: MWAIT is tied into a constant-false stall term.
  assign w_hold = MWAIT & 1'b0;
`endif

  // Next-state selection; an illegal register value falls back to IF0.
  always_comb begin
    w_nextState = S_IF0;
    w_enterIt   = op_SVC | ((EIT_gate | OIT_gate) & ~op_RIT);
    if (!w_legal) begin
      w_nextState = S_IF0;
    end else if (w_hold) begin
      w_nextState = w_curState;
    end else begin
      case (w_curState)
        S_IF0:    w_nextState = S_IF1;
        S_IF1:    w_nextState = f_is_D ? S_FF0 : (t_is_D ? S_TF0 : S_EX0);
        S_FF0:    w_nextState = S_FF1;
        S_FF1:    w_nextState = S_FF2;
        S_FF2:    w_nextState = t_is_D ? S_TF0 : S_EX0;
        S_TF0:    w_nextState = is_T_DFive ? S_EX0 : S_TF1;
        S_TF1:    w_nextState = S_EX0;
        S_EX0:    w_nextState = op_MUL ? S_MUL1 : S_EX1;
        S_EX1:    w_nextState = w_enterIt ? S_IT0 : S_IF0;
        S_IT0:    w_nextState = S_IT1;
        S_IT1:    w_nextState = S_IT2;
        S_IT2:    w_nextState = S_IF0;
        S_MUL1:   w_nextState = S_MUL2_1;
        S_MUL2_1: w_nextState = S_MUL2_2;
        S_MUL2_2: w_nextState = w_mulTerminal ? S_MUL3 : S_MUL2_1;
        S_MUL3:   w_nextState = S_MUL4;
        S_MUL4:   w_nextState = w_enterIt ? S_IT0 : S_IF0;
        default:  w_nextState = S_IF0;
      endcase
    end
  end

  // Counter control: clear while in MUL1, step on each looping MUL2_2.
  always_comb begin
    w_cntClear = w_legal && (w_curState == S_MUL1);
    w_cntInc   = w_legal && (w_curState == S_MUL2_2) && !w_mulTerminal && !w_hold;
  end

  // One-hot state register; reset aborts straight to IF0.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state <= ONEHOT_IF0;
    end else begin
      r_state <= state_vec_t'(1) << w_nextState;
    end
  end

  mul_iter_counter #(
    .MUL_ITER (MUL_ITER),
    .CNT_W    (CNT_W)
  ) u_mulIterCounter (
    .CLK        (CLK),
    .CLR        (CLR),
    .i_clear    (w_cntClear),
    .i_inc      (w_cntInc),
    .o_terminal (w_mulTerminal)
  );

  assign IF0        = r_state[S_IF0];
  assign IF1        = r_state[S_IF1];
  assign FF0        = r_state[S_FF0];
  assign FF1        = r_state[S_FF1];
  assign FF2        = r_state[S_FF2];
  assign TF0        = r_state[S_TF0];
  assign TF1        = r_state[S_TF1];
  assign EX0        = r_state[S_EX0];
  assign EX1        = r_state[S_EX1];
  assign IT0        = r_state[S_IT0];
  assign IT1        = r_state[S_IT1];
  assign IT2        = r_state[S_IT2];
  assign MUL1       = r_state[S_MUL1];
  assign MUL2_1     = r_state[S_MUL2_1];
  assign MUL2_2     = r_state[S_MUL2_2];
  assign MUL3       = r_state[S_MUL3];
  assign MUL4       = r_state[S_MUL4];
  assign MUL_LAST   = r_state[S_MUL2_2] & w_mulTerminal;
  assign STATE_CODE = encodeState(r_state);

endmodule

// File: tb/tb_state_sequencer.sv
// Self-checking bench for state_sequencer. Expected phase sequences are built
// from the instruction hints and queued, then popped and compared one per cycle.
// With SEQ_MWAIT_EN defined the MWAIT scenario expects IF1 to stretch.
module tb_state_sequencer;

  localparam int MUL_ITER = 16;

  localparam logic [4:0] C_IF0 = 5'd0,  C_IF1 = 5'd1,  C_FF0 = 5'd2,  C_FF1 = 5'd3;
  localparam logic [4:0] C_FF2 = 5'd4,  C_TF0 = 5'd5,  C_TF1 = 5'd6,  C_EX0 = 5'd7;
  localparam logic [4:0] C_EX1 = 5'd8,  C_IT0 = 5'd9,  C_IT1 = 5'd10, C_IT2 = 5'd11;
  localparam logic [4:0] C_MUL1 = 5'd12, C_MUL2_1 = 5'd13, C_MUL2_2 = 5'd14;
  localparam logic [4:0] C_MUL3 = 5'd15, C_MUL4 = 5'd16;

  typedef struct packed {
    logic [4:0] code;
    logic       last;
  } exp_t;

  logic CLK, CLR;
  logic f_is_D, t_is_D, is_T_DFive, op_MUL, op_RIT, op_SVC, EIT_gate, OIT_gate, MWAIT;
  logic IF0, IF1, FF0, FF1, FF2, TF0, TF1, EX0, EX1, IT0, IT1, IT2;
  logic MUL1, MUL2_1, MUL2_2, MUL3, MUL4, MUL_LAST;
  logic [4:0] STATE_CODE;
  logic [16:0] strobes;

  exp_t expQ[$];
  int numCompared;
  int numMismatched;

  state_sequencer #(.MUL_ITER(MUL_ITER), .CNT_W(5)) dut (
    .CLK(CLK), .CLR(CLR),
    .f_is_D(f_is_D), .t_is_D(t_is_D), .is_T_DFive(is_T_DFive),
    .op_MUL(op_MUL), .op_RIT(op_RIT), .op_SVC(op_SVC),
    .EIT_gate(EIT_gate), .OIT_gate(OIT_gate), .MWAIT(MWAIT),
    .IF0(IF0), .IF1(IF1), .FF0(FF0), .FF1(FF1), .FF2(FF2),
    .TF0(TF0), .TF1(TF1), .EX0(EX0), .EX1(EX1),
    .IT0(IT0), .IT1(IT1), .IT2(IT2),
    .MUL1(MUL1), .MUL2_1(MUL2_1), .MUL2_2(MUL2_2), .MUL3(MUL3), .MUL4(MUL4),
    .MUL_LAST(MUL_LAST), .STATE_CODE(STATE_CODE)
  );

  assign strobes = {MUL4, MUL3, MUL2_2, MUL2_1, MUL1, IT2, IT1, IT0,
                    EX1, EX0, TF1, TF0, FF2, FF1, FF0, IF1, IF0};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic pushState(input logic [4:0] code, input logic last);
    exp_t e;
    e.code = code;
    e.last = last;
    expQ.push_back(e);
  endtask

  // Builds the phase sequence one instruction should produce from its hints.
  task automatic buildExpected(input logic f, input logic t, input logic d5,
                               input logic mul, input logic svc, input logic rit,
                               input logic irq, input int mwaitN);
    pushState(C_IF0, 1'b0);
    pushState(C_IF1, 1'b0);
`ifdef SEQ_MWAIT_EN
    for (int i = 0; i < mwaitN; i++) pushState(C_IF1, 1'b0);
`endif
    if (f) begin
      pushState(C_FF0, 1'b0);
      pushState(C_FF1, 1'b0);
      pushState(C_FF2, 1'b0);
    end
    if (t) begin
      pushState(C_TF0, 1'b0);
      if (!d5) pushState(C_TF1, 1'b0);
    end
    pushState(C_EX0, 1'b0);
    if (mul) begin
      pushState(C_MUL1, 1'b0);
      for (int k = 0; k < MUL_ITER; k++) begin
        pushState(C_MUL2_1, 1'b0);
        pushState(C_MUL2_2, (k == MUL_ITER - 1));
      end
      pushState(C_MUL3, 1'b0);
      pushState(C_MUL4, 1'b0);
    end else begin
      pushState(C_EX1, 1'b0);
    end
    if (svc || (irq && !rit)) begin
      pushState(C_IT0, 1'b0);
      pushState(C_IT1, 1'b0);
      pushState(C_IT2, 1'b0);
    end
  endtask

  // Pops one expected phase and compares code, strobe vector and MUL_LAST.
  task automatic popAndCheck(input string name, input int step);
    exp_t e;
    e = expQ.pop_front();
    checkOutput($sformatf("%s.code[%0d]", name, step), 32'(STATE_CODE), 32'(e.code));
    checkOutput($sformatf("%s.strobes[%0d]", name, step), 32'(strobes),
                32'(17'(1) << e.code));
    checkOutput($sformatf("%s.mulLast[%0d]", name, step), 32'(MUL_LAST), 32'(e.last));
  endtask

  // Runs one instruction from IF0 to the next IF0, starting at a falling edge.
  task automatic applyStimulus(input string name, input logic f, input logic t,
                               input logic d5, input logic mul, input logic svc,
                               input logic rit, input logic eit, input logic oit,
                               input int mwaitN);
    int step;
    f_is_D = f; t_is_D = t; is_T_DFive = d5; op_MUL = mul;
    op_SVC = svc; op_RIT = rit; EIT_gate = eit; OIT_gate = oit; MWAIT = 1'b0;
    buildExpected(f, t, d5, mul, svc, rit, eit | oit, mwaitN);
    step = 0;
    while (expQ.size() > 0) begin
      popAndCheck(name, step);
      MWAIT = (step >= 1) && (step <= mwaitN);
      @(posedge CLK);
      @(negedge CLK);
      step++;
    end
    MWAIT = 1'b0;
  endtask

  initial begin
    numCompared = 0;
    numMismatched = 0;
    CLR = 1'b1;
    f_is_D = 0; t_is_D = 0; is_T_DFive = 0; op_MUL = 0;
    op_RIT = 0; op_SVC = 0; EIT_gate = 0; OIT_gate = 0; MWAIT = 0;

    @(negedge CLK);
    checkOutput("reset.strobes", 32'(strobes), 32'h1);
    checkOutput("reset.code", 32'(STATE_CODE), 32'h0);
    checkOutput("reset.mulLast", 32'(MUL_LAST), 32'h0);
    CLR = 1'b0;

    //                   name       f  t  d5 mul svc rit eit oit mw
    applyStimulus("alu",      0, 0, 0, 0,  0,  0,  0,  0,  0);
    applyStimulus("ffTf",     1, 1, 0, 0,  0,  0,  0,  0,  0);
    applyStimulus("tfD5",     0, 1, 1, 0,  0,  0,  0,  0,  0);
    applyStimulus("ffOnly",   1, 0, 0, 0,  0,  0,  0,  0,  0);
    applyStimulus("mul",      0, 0, 0, 1,  0,  0,  0,  0,  0);
    applyStimulus("eit",      0, 0, 0, 0,  0,  0,  1,  0,  0);
    applyStimulus("eitRit",   0, 0, 0, 0,  0,  1,  1,  0,  0);
    applyStimulus("svc",      0, 0, 0, 0,  1,  0,  0,  0,  0);
    applyStimulus("svcRitIrq",0, 0, 0, 0,  1,  1,  1,  1,  0);
    applyStimulus("mulOit",   1, 1, 1, 1,  0,  0,  0,  1,  0);
    applyStimulus("mwait",    0, 0, 0, 0,  0,  0,  0,  0,  3);

    // Asynchronous abort in the middle of the multiply loop (4th MUL2_2).
    f_is_D = 0; t_is_D = 0; is_T_DFive = 0; op_MUL = 1;
    op_SVC = 0; op_RIT = 0; EIT_gate = 0; OIT_gate = 0;
    buildExpected(0, 0, 0, 1, 0, 0, 0, 0);
    for (int s = 0; s <= 11; s++) begin
      popAndCheck("abort", s);
      if (s < 11) begin
        @(posedge CLK);
        @(negedge CLK);
      end
    end
    #1 CLR = 1'b1;
    #1;
    checkOutput("abort.strobes", 32'(strobes), 32'h1);
    checkOutput("abort.code", 32'(STATE_CODE), 32'h0);
    checkOutput("abort.mulLast", 32'(MUL_LAST), 32'h0);
    expQ.delete();
    @(negedge CLK);
    checkOutput("abortHeld.code", 32'(STATE_CODE), 32'h0);
    CLR = 1'b0;
    applyStimulus("mulAfterAbort", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus("aluFinal",      0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
